// File: rtl/ln_bram_pack_buffer_if.sv
// Write stream (demux BRAM-store path) and packed read stream of the frame buffer.
interface ln_bram_pack_buffer_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  logic               wr_valid;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_ready;
  logic [N*WIDTH-1:0] out_vec;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output wr_valid, wr_data, out_ready,
    input  wr_ready, out_vec, out_valid
  );

  modport slave (
    input  wr_valid, wr_data, out_ready,
    output wr_ready, out_vec, out_valid
  );
endinterface

// File: rtl/ln_bram_pack_buffer.sv
// Frame buffer: fills an SDP BRAM with single words, then drains it as N-word packed vectors.
// Each group issues N reads, waits for acceptance of the assembled vector, then moves on (no prefetch).
module ln_bram_pack_buffer #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [AW:0]          frame_len,
  ln_bram_pack_buffer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(N + 1);
  localparam logic [AW:0]   LEN_N = (AW+1)'(N);
  localparam logic [AW:0]   LEN_D = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] ISS_N = IW'(N);
  localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [AW:0]        len_q, wcnt, rcnt, rcnt_nxt;
  logic [IW-1:0]      iss;
  logic               rd_en, rd_vld;
  logic [SW-1:0]      rd_slot;
  logic [AW-1:0]      rd_addr;
  logic [WIDTH-1:0]   rd_q;
  logic [N*WIDTH-1:0] asm_q, merged, out_vec_q;
  logic               out_valid_q;
  logic               legal, wr_en, fill_end, accept, last_grp;

  logic [WIDTH-1:0]   mem [DEPTH];

  assign legal    = (frame_len != '0) && (frame_len <= LEN_D) && ((frame_len % LEN_N) == '0);
  assign wr_en    = (state == FILL) && bus.wr_valid;
  assign fill_end = wr_en && ((wcnt + 1'b1) == len_q);
  assign rd_en    = (state == DRAIN) && (iss < ISS_N);
  assign rd_addr  = rcnt[AW-1:0] + AW'(iss);
  assign accept   = out_valid_q && bus.out_ready;
  assign rcnt_nxt = rcnt + LEN_N;
  assign last_grp = (rcnt_nxt == len_q);

  assign bus.wr_ready  = (state == FILL);
  assign bus.out_vec   = out_vec_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state != IDLE);

  // BRAM contents survive reset; the read register freezes with en so in-flight reads resume intact.
  always_ff @(posedge clk) begin
    if (en && wr_en) begin
      mem[wcnt[AW-1:0]] <= bus.wr_data;
    end
    if (en && rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  always_comb begin
    merged = asm_q;
    merged[int'(rd_slot)*WIDTH +: WIDTH] = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    if (start && legal)     state_nxt = FILL;
        FILL:    if (fill_end)           state_nxt = DRAIN;
        DRAIN:   if (accept && last_grp) state_nxt = IDLE;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      iss         <= '0;
      rd_vld      <= 1'b0;
      rd_slot     <= '0;
      asm_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else if (en) begin
      done   <= 1'b0;
      err    <= (start && (state == IDLE) && !legal) || (bus.wr_valid && (state != FILL));
      rd_vld <= rd_en;
      if (rd_en) begin
        iss     <= iss + 1'b1;
        rd_slot <= iss[SW-1:0];
      end
      // The final word of a group goes straight into out_vec to save a cycle.
      if (rd_vld) begin
        if (rd_slot == SLOT_LAST) begin
          out_vec_q   <= merged;
          out_valid_q <= 1'b1;
        end else begin
          asm_q <= merged;
        end
      end
      if ((state == IDLE) && start && legal) begin
        len_q <= frame_len;
        wcnt  <= '0;
        rcnt  <= '0;
        iss   <= '0;
      end
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
      end
      if (accept) begin
        out_valid_q <= 1'b0;
        rcnt        <= rcnt_nxt;
        iss         <= '0;
        done        <= last_grp;
      end
    end
  end
endmodule

// File: tb/tb_ln_bram_pack_buffer.sv
// Bench for ln_bram_pack_buffer: scenario tasks against a word-list model of the packed frame.
module tb_ln_bram_pack_buffer;
  localparam int N = 4, W = 16, DEPTH = 64, AW = 6;

  logic clk = 1'b0;
  logic rst, en, start;
  logic [AW:0] frame_len;
  logic busy, done, err;

  ln_bram_pack_buffer_if #(.N(N), .WIDTH(W)) bus();

  ln_bram_pack_buffer #(.N(N), .WIDTH(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .frame_len(frame_len),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic [W-1:0]   words[$];
  logic [N*W-1:0] got[$];
  int got_cyc[$];
  int first_valid, drain_entry, done_cnt, err_cnt, stable_bad, timeout, start_cyc, end_cyc;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [N*W-1:0] exp_vec(int k);
    logic [N*W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*W +: W] = words[k*N+j];
    return v;
  endfunction

  task automatic gen_words(input int len, input bit seq);
    words.delete();
    for (int i = 0; i < len; i++) words.push_back(seq ? W'(i + 1) : W'($urandom));
  endtask

  task automatic start_frame(input int len);
    frame_len = (AW+1)'(len);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic fill(input bit gaps, input int gate_at);
    for (int i = 0; i < words.size(); i++) begin
      if (gaps) begin
        bus.wr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = words[i];
      if (i == gate_at) begin
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready, input bit stall_first, input int gate_at, input int stray_at);
    int stall;
    logic [N*W-1:0] held;
    stall = 0; held = '0;
    got.delete(); got_cyc.delete();
    first_valid = -1; done_cnt = 0; err_cnt = 0; stable_bad = 0; timeout = 1;
    drain_entry = cyc;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        done_cnt++;
        timeout = 0;
        end_cyc = cyc;
        break;
      end
      if (err) err_cnt++;
      if (c == gate_at) begin
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
      end
      bus.wr_valid = (c == stray_at);
      bus.wr_data  = 16'hDEAD;
      if (bus.out_valid && first_valid < 0) begin
        first_valid = cyc;
        if (stall_first) begin stall = 10; held = bus.out_vec; end
      end
      if (stall > 0) begin
        if (bus.out_vec !== held || bus.out_valid !== 1'b1) stable_bad++;
        stall--;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_vec);
        got_cyc.push_back(cyc);
      end
      tick();
    end
    bus.wr_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    tests++; if (bus.out_vec !== '0) begin fails++; $display("FAIL reset_out_vec got %h exp 0", bus.out_vec); end
    tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got %b exp 0", bus.wr_ready); end
    tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_busy_done_err got %b exp 000", {busy, done, err}); end
    rst = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_after got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    gen_words(8, 1'b1);
    start_frame(8);
    tests++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL basic_fill_state got %b exp 1", bus.wr_ready); end
    fill(1'b0, -1);
    drain(1'b0, 1'b0, -1, -1);
    tests++; if (timeout !== 0) begin fails++; $display("FAIL basic_timeout got %0d exp 0", timeout); end
    tests++; if (drain_entry !== start_cyc + 9) begin fails++; $display("FAIL basic_drain_entry got %0d exp %0d", drain_entry - start_cyc, 9); end
    tests++; if (first_valid - drain_entry !== N + 1) begin fails++; $display("FAIL basic_first_valid got %0d exp %0d", first_valid - drain_entry, N + 1); end
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL basic_count got %0d exp 2", got.size()); end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      tests++; if (got[k] !== exp_vec(k)) begin fails++; $display("FAIL basic_vec%0d got %h exp %h", k, got[k], exp_vec(k)); end
      tests++; if (got_cyc[k] !== start_cyc + 8 + (k + 1) * (N + 2)) begin fails++; $display("FAIL basic_cyc%0d got %0d exp %0d", k, got_cyc[k] - start_cyc, 8 + (k + 1) * (N + 2)); end
    end
    tests++; if (got.size() > 0 && end_cyc !== got_cyc[got.size()-1] + 1) begin fails++; $display("FAIL basic_done_cyc got %0d exp %0d", end_cyc, got_cyc[got.size()-1] + 1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_backpressure();
    gen_words(8, 1'b1);
    start_frame(8);
    fill(1'b0, -1);
    drain(1'b0, 1'b1, -1, -1);
    tests++; if (stable_bad !== 0) begin fails++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stable_bad); end
    tests++; if (got.size() !== 2 || done_cnt !== 1) begin fails++; $display("FAIL bp_count got %0d/%0d exp 2/1", got.size(), done_cnt); end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      tests++; if (got[k] !== exp_vec(k)) begin fails++; $display("FAIL bp_vec%0d got %h exp %h", k, got[k], exp_vec(k)); end
    end
    tests++; if (got.size() == 2 && got_cyc[1] !== start_cyc + 30) begin fails++; $display("FAIL bp_second_cyc got %0d exp 30", got_cyc[1] - start_cyc); end
  endtask

  task automatic test_illegal_start();
    int bad[3];
    bad[0] = 0; bad[1] = 6; bad[2] = 65;
    for (int i = 0; i < 3; i++) begin
      start_frame(bad[i]);
      tests++; if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL illegal_%0d err/busy got %b%b exp 10", bad[i], err, busy); end
      tick();
      tests++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL illegal_%0d pulse got %b%b exp 00", bad[i], err, busy); end
    end
    gen_words(64, 1'b0);
    start_frame(64);
    tests++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL full_start err/busy got %b%b exp 01", err, busy); end
    fill(1'b0, -1);
    drain(1'b0, 1'b0, -1, -1);
    tests++; if (got.size() !== 16 || done_cnt !== 1) begin fails++; $display("FAIL full_count got %0d/%0d exp 16/1", got.size(), done_cnt); end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      tests++; if (got[k] !== exp_vec(k)) begin fails++; $display("FAIL full_vec%0d got %h exp %h", k, got[k], exp_vec(k)); end
    end
  endtask

  task automatic test_stray_writes();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hBEEF;
    tick();
    bus.wr_valid = 1'b0;
    tests++; if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL stray_idle err/busy got %b%b exp 10", err, busy); end
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL stray_idle_pulse got %b exp 0", err); end
    gen_words(8, 1'b0);
    start_frame(8);
    fill(1'b0, -1);
    drain(1'b0, 1'b0, -1, 7);
    tests++; if (err_cnt !== 1) begin fails++; $display("FAIL stray_drain_err got %0d exp 1", err_cnt); end
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL stray_count got %0d exp 2", got.size()); end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      tests++; if (got[k] !== exp_vec(k)) begin fails++; $display("FAIL stray_vec%0d got %h exp %h", k, got[k], exp_vec(k)); end
    end
  endtask

  task automatic test_enable_gating();
    gen_words(8, 1'b0);
    start_frame(8);
    fill(1'b0, 3);
    drain(1'b0, 1'b0, 2, -1);
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL gate_count got %0d exp 2", got.size()); end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      tests++; if (got[k] !== exp_vec(k)) begin fails++; $display("FAIL gate_vec%0d got %h exp %h", k, got[k], exp_vec(k)); end
      tests++; if (got_cyc[k] !== start_cyc + 8 + (k + 1) * (N + 2) + 6) begin fails++; $display("FAIL gate_cyc%0d got %0d exp %0d", k, got_cyc[k] - start_cyc, 8 + (k + 1) * (N + 2) + 6); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    gen_words(8, 1'b0);
    start_frame(8);
    fill(1'b0, -1);
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rst_first_valid got %b exp 1", bus.out_valid); end
    tick();
    rst = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_vec !== '0) begin fails++; $display("FAIL rst_outputs got %b/%h exp 0/0", bus.out_valid, bus.out_vec); end
    tests++; if ({busy, done, err, bus.wr_ready} !== 4'b0000) begin fails++; $display("FAIL rst_flags got %b exp 0000", {busy, done, err, bus.wr_ready}); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    gen_words(4, 1'b0);
    start_frame(4);
    fill(1'b0, -1);
    drain(1'b0, 1'b0, -1, -1);
    tests++; if (got.size() !== 1 || done_cnt !== 1) begin fails++; $display("FAIL rst_new_count got %0d/%0d exp 1/1", got.size(), done_cnt); end
    tests++; if (got.size() > 0 && got[0] !== exp_vec(0)) begin fails++; $display("FAIL rst_new_vec got %h exp %h", got[0], exp_vec(0)); end
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 6; f++) begin
      len = N * $urandom_range(1, DEPTH / N);
      gen_words(len, 1'b0);
      start_frame(len);
      fill(1'b1, -1);
      drain(1'b1, 1'b0, -1, -1);
      tests++; if (got.size() !== len / N || timeout !== 0) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d (timeout %0d)", f, got.size(), len / N, timeout); end
      for (int k = 0; k < got.size() && k < len / N; k++) begin
        tests++; if (got[k] !== exp_vec(k)) begin fails++; $display("FAIL rand%0d_vec%0d got %h exp %h", f, k, got[k], exp_vec(k)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; frame_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal_start();
    test_stray_writes();
    test_enable_gating();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ln_bram_pack_buffer.md
# ln_bram_pack_buffer

Frame buffer that sits directly downstream of the LayerNorm bypass demux. It collects the WIDTH-bit words the demux emits on its BRAM-store path into an inferred simple-dual-port BRAM, then drains the stored frame back out as N-word packed vectors with a valid/ready handshake. The N-word vector width matches the demux's direct-output path.

## Interface
- N, 4, words per packed output vector
- WIDTH, 16, bits per word
- DEPTH, 64, BRAM depth in words; must be a multiple of N
- AW, $clog2(DEPTH), address width
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset: asynchronous, active-high
- en  input  1  global enable; when low, all state, counters and outputs hold, and handshakes are not accepted
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE
- frame_len  input  AW+1  frame length in words, sampled on an accepted start
- wr_valid  input  1  wr_data is valid
- wr_data  input  WIDTH  word from the demux bram_data_in
- wr_ready  output  1  high only in FILL
- out_vec  output  N*WIDTH  packed vector; word k occupies bits [k*WIDTH +: WIDTH], and the lowest address maps to k=0
- out_valid  output  1  out_vec is valid; held until accepted
- out_ready  input  1  consumer accepts when out_valid && out_ready && en
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after the last vector is accepted
- err  output  1  one-cycle pulse on a rejected start, or on wr_valid outside FILL

## Operation
- States: IDLE, FILL, DRAIN.
- Reset values:
  - state = IDLE
  - write counter wcnt = 0, read counter rcnt = 0
  - out_vec = 0, out_valid = 0, wr_ready = 0, busy = 0, done = 0, err = 0
  - BRAM contents are not cleared.
- IDLE:
  - A start with frame_len in 1..DEPTH and frame_len % N == 0 latches the length, clears both counters and moves to FILL.
  - A start with any other frame_len is ignored and pulses err.
- FILL:
  - Each cycle with en && wr_valid writes wr_data to address wcnt, then wcnt++.
  - The write that brings wcnt to the latched length moves the block to DRAIN on the same edge.
- DRAIN:
  - The block issues N consecutive reads at rcnt..rcnt+N-1. BRAM read latency is 1 cycle.
  - Returning words are placed into the assembly register at slot (address mod N).
  - After the N-th word is captured, the assembled value loads into out_vec and out_valid rises.
  - The next group's reads do not start until the current vector is accepted. There is no prefetch.
  - On acceptance, rcnt += N. If rcnt then equals the latched length: pulse done, out_valid = 0, return to IDLE. Otherwise start the next group.
- A start received outside IDLE is ignored, with no err.
- wr_valid outside FILL: the data is dropped and err pulses. This is an upstream sequencing fault.
- Reset asserted mid-frame: the block returns immediately to IDLE, counters clear, and any partial vector is discarded.
- out_vec holds its last value after out_valid falls.

## Timing
- Let t0 be the first cycle in FILL. With wr_valid held high, the frame_len-th word is written at t0 + frame_len − 1, and the block is in DRAIN at t0 + frame_len.
- Let d0 be the first cycle in DRAIN, or the cycle after an acceptance. out_valid is high at d0 + N + 1 (5 cycles for N = 4).
- Per-vector throughput with out_ready held high is N + 2 cycles.
- done is high in the cycle after the final accepting edge. The block is in IDLE in that same cycle and can accept start in that same cycle.
- err and done are registered single-cycle pulses.
- en low freezes the pipeline, including in-flight BRAM reads: the read data register holds. Output resumes with unchanged cycle counts once en returns high.

## Test plan
- Basic frame: N=4, start with frame_len=8, write words 0x0001..0x0008 back-to-back, out_ready=1.
  - Two vectors: 0x0004_0003_0002_0001, then 0x0008_0007_0006_0005.
  - done pulses once; busy falls; first out_valid occurs 5 cycles after DRAIN entry.
- Backpressure: same frame, out_ready=0 for 10 cycles after the first out_valid.
  - out_vec and out_valid are stable for all 10 cycles; no word is skipped or duplicated after release.
- Illegal starts: frame_len = 0, 6 and 65 (DEPTH = 64).
  - err pulses each time and state stays IDLE.
  - Then frame_len = 64 completes with 16 vectors.
- Stray writes: wr_valid=1 in IDLE and during DRAIN → err pulses and BRAM contents are unchanged.
  - Verify by re-reading the frame.
- Enable gating: drop en for 3 cycles in the middle of FILL and in the middle of DRAIN.
  - Output data is identical to the un-gated run, shifted by exactly 3 cycles each time.
- Reset mid-DRAIN: assert rst after the first vector is accepted.
  - All outputs return to reset values immediately.
  - A new frame_len=4 frame then drains correctly.
